// File: rtl/control_enemigos_pkg.sv
// Shared constants for the enemy scheduler, sprite renderers and collision block.
// Screen geometry, lane positions, RGB332 layout and the spawn FSM state type.
package control_enemigos_pkg;

  localparam int unsigned V_VISIBLE        = 480;
  localparam int unsigned H_VISIBLE        = 640;
  localparam int unsigned SPRITE_H         = 60;
  localparam int unsigned SPRITE_W         = 60;
  localparam int unsigned NSLOT            = 3;
  localparam int unsigned NLANE            = 3;
  localparam int unsigned SPAWN_FRAMES_DEF = 90;
  localparam int unsigned STEP_BASE_DEF    = 2;

  localparam logic [9:0] LANE_X0 = 10'd200;
  localparam logic [9:0] LANE_X1 = 10'd290;
  localparam logic [9:0] LANE_X2 = 10'd380;

  localparam int unsigned R_W   = 3;
  localparam int unsigned G_W   = 3;
  localparam int unsigned B_W   = 2;
  localparam int unsigned RGB_W = R_W + G_W + B_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SPAWN
  } spawn_st_e;

  function automatic logic [9:0] lane_x(input logic [1:0] lane);
    case (lane)
      2'd0:    return LANE_X0;
      2'd1:    return LANE_X1;
      default: return LANE_X2;
    endcase
  endfunction

  function automatic logic [1:0] lane_wrap(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return 2'((s >= 3'd3) ? s - 3'd3 : s);
  endfunction

endpackage

// File: rtl/control_enemigos_lfsr_carril.sv
// 3-bit maximal-length LFSR (x^3+x^2+1) used to pick the spawn lane.
module lfsr_carril (
  input  logic       clock,
  input  logic       reset,
  input  logic       step,
  output logic [2:0] value
);

  logic [2:0] r_lfsr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_lfsr <= 3'b001;
    end else if (step) begin
      r_lfsr <= {r_lfsr[1:0], r_lfsr[2] ^ r_lfsr[1]};
    end
  end

  assign value = r_lfsr;

endmodule

// File: rtl/control_enemigos.sv
// Enemy slot scheduler: spawns, scrolls and retires three enemies once per frame,
// and arbitrates the renderers' pixel outputs into one registered RGB stream.
module control_enemigos
  import control_enemigos_pkg::*;
#(
  parameter int unsigned SPAWN_FRAMES = SPAWN_FRAMES_DEF,
  parameter int unsigned STEP_BASE    = STEP_BASE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [1:0]  velocidad,
  input  logic [2:0]  colision,
  input  logic [2:0]  data_in,
  input  logic [23:0] rgb_in,
  output logic [2:0]  en,
  output logic [29:0] posx_bus,
  output logic [29:0] posy_bus,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        data,
  output logic        pasado
);

  logic             w_tick;
  logic [2:0]       w_lfsr;
  spawn_st_e        r_state, w_state_nxt;
  logic [6:0]       r_cnt, w_cnt_nxt;
  logic             w_attempt, w_do_spawn;
  logic [2:0]       w_free, w_spawn_oh, w_blocked, w_retire, w_pix_hit;
  logic [1:0]       w_base, w_lane;
  logic             w_lane_ok;
  logic [9:0]       w_spawn_x;
  logic [9:0]       w_posx [NSLOT];
  logic [9:0]       w_posy [NSLOT];
  logic [RGB_W-1:0] w_pix_rgb, r_rgb;
  logic             r_data, r_pasado;

  assign w_tick = (vcount == 10'(V_VISIBLE)) && (hcount == '0);

  lfsr_carril u_lfsr (
    .clock (clock),
    .reset (reset),
    .step  (1'b1),
    .value (w_lfsr)
  );

  // Lane search uses the pre-tick picture, same as the free mask.
  always_comb begin
    logic [1:0] v_cand;
    v_cand    = '0;
    w_blocked = '0;
    for (int unsigned s = 0; s < NSLOT; s++)
      for (int unsigned l = 0; l < NLANE; l++)
        if (en[s] && (w_posx[s] == lane_x(2'(l))) && (w_posy[s] < 10'(SPRITE_H)))
          w_blocked[l] = 1'b1;
    w_base    = 2'(w_lfsr % 3'd3);
    w_lane    = '0;
    w_lane_ok = 1'b0;
    for (int unsigned k = 0; k < NLANE; k++) begin
      v_cand = lane_wrap(w_base, 2'(k));
      if (!w_lane_ok && !w_blocked[v_cand]) begin
        w_lane    = v_cand;
        w_lane_ok = 1'b1;
      end
    end
  end

  assign w_free    = ~en;
  assign w_spawn_x = lane_x(w_lane);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_attempt   = 1'b0;
    if (w_tick && enable) begin
      w_attempt = (r_state == ST_ARMED) || (({1'b0, r_cnt} + 8'd1) >= 8'(SPAWN_FRAMES));
      if (!w_attempt) w_cnt_nxt = r_cnt + 7'd1;
    end
    w_do_spawn = w_attempt && (|w_free) && w_lane_ok;
    w_spawn_oh = w_do_spawn ? (w_free & (~w_free + 3'd1)) : '0;
    if (w_do_spawn)     w_cnt_nxt = '0;
    else if (w_attempt) w_cnt_nxt = 7'(SPAWN_FRAMES);
    case (r_state)
      ST_IDLE: begin
        if (w_do_spawn)     w_state_nxt = ST_SPAWN;
        else if (w_attempt) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_do_spawn) w_state_nxt = ST_SPAWN;
      end
      ST_SPAWN: begin
        if (w_do_spawn)     w_state_nxt = ST_SPAWN;
        else if (w_attempt) w_state_nxt = ST_ARMED;
        else                w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    logic        r_en, r_kill;
    logic [9:0]  r_posx, r_posy;
    logic [10:0] w_sum;
    logic        w_kill_now;

    assign w_sum        = {1'b0, r_posy} + 11'(STEP_BASE) + {9'd0, velocidad};
    assign w_kill_now   = r_kill | colision[gi];
    assign w_retire[gi] = w_tick && enable && r_en && !w_kill_now && (w_sum >= 11'(V_VISIBLE));

    always_ff @(posedge clock) begin
      if (!reset) begin
        r_en   <= 1'b0;
        r_kill <= 1'b0;
        r_posx <= '0;
        r_posy <= '0;
      end else begin
        if (w_tick)            r_kill <= 1'b0;
        else if (colision[gi]) r_kill <= 1'b1;
        if (w_tick) begin
          if (w_spawn_oh[gi]) begin
            r_en   <= 1'b1;
            r_posx <= w_spawn_x;
            r_posy <= '0;
          end else if (r_en) begin
            if (w_kill_now)                        r_en   <= 1'b0;
            else if (enable && w_sum >= 11'(V_VISIBLE)) r_en   <= 1'b0;
            else if (enable)                       r_posy <= w_sum[9:0];
          end
        end
      end
    end

    assign en[gi]              = r_en;
    assign w_posx[gi]          = r_posx;
    assign w_posy[gi]          = r_posy;
    assign posx_bus[gi*10 +: 10] = r_posx;
    assign posy_bus[gi*10 +: 10] = r_posy;
  end

  // Descending scan so the lowest live slot overrides.
  always_comb begin
    w_pix_hit = data_in & en;
    w_pix_rgb = '0;
    for (int unsigned s = NSLOT; s > 0; s--)
      if (w_pix_hit[s-1]) w_pix_rgb = rgb_in[(s-1)*RGB_W +: RGB_W];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_pasado <= 1'b0;
      r_data   <= 1'b0;
      r_rgb    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pasado <= |w_retire;
      r_data   <= |w_pix_hit;
      if (|w_pix_hit) r_rgb <= w_pix_rgb;
    end
  end

  assign red    = r_rgb[RGB_W-1 -: R_W];
  assign green  = r_rgb[B_W +: G_W];
  assign blue   = r_rgb[B_W-1:0];
  assign data   = r_data;
  assign pasado = r_pasado;

endmodule

// File: tb/tb_control_enemigos.sv
// Randomized bench for control_enemigos: a frame-level reference model pushes the
// expected post-edge outputs into a queue; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_control_enemigos;

  localparam int SF = 2;

  typedef struct packed {
    logic [2:0]  en;
    logic [2:0]  cmp;
    logic [29:0] x;
    logic [29:0] y;
    logic        data;
    logic [7:0]  rgb;
    logic        pas;
  } exp_t;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_in = 1'b1;
  logic [9:0]  hc = 10'd1, vc = 10'd0;
  logic [1:0]  vel = 2'd0;
  logic [2:0]  col = 3'd0, din = 3'd0;
  logic [23:0] rgbi = 24'd0;
  logic [2:0]  en_o, red_o, green_o;
  logic [1:0]  blue_o;
  logic [29:0] posx_o, posy_o;
  logic        data_o, pas_o;

  int n_checks = 0;
  int n_err    = 0;
  int col_rate = 0;
  bit want_hr  = 0;

  exp_t q[$];

  control_enemigos #(.SPAWN_FRAMES(SF)) dut (
    .clock(clock), .reset(rst_n), .enable(en_in), .hcount(hc), .vcount(vc),
    .velocidad(vel), .colision(col), .data_in(din), .rgb_in(rgbi),
    .en(en_o), .posx_bus(posx_o), .posy_bus(posy_o), .red(red_o),
    .green(green_o), .blue(blue_o), .data(data_o), .pasado(pas_o)
  );

  always #5 clock = ~clock;

  // Reference model: LFSR as its 7-state sequence, slots as plain integers.
  int lfsr_seq [7] = '{1, 2, 5, 3, 7, 6, 4};
  int lane_xs  [3] = '{200, 290, 380};
  bit m_live[3], m_used[3], m_kill[3];
  int m_x[3], m_y[3];
  int m_cnt = 0, m_idx = 0;
  bit m_data = 0, m_pas = 0;
  logic [7:0] m_rgb = 8'd0;

  always @(posedge clock) begin
    exp_t e;
    bit found, blocked[3];
    int slot, lane, base;
    if (!rst_n) begin
      for (int s = 0; s < 3; s++) begin
        m_live[s] = 0; m_used[s] = 0; m_kill[s] = 0; m_x[s] = 0; m_y[s] = 0;
      end
      m_cnt = 0; m_idx = 0; m_data = 0; m_pas = 0; m_rgb = 8'd0;
    end else begin
      found = 0;
      for (int s = 0; s < 3; s++)
        if (!found && m_live[s] && din[s]) begin found = 1; m_rgb = rgbi[8*s +: 8]; end
      m_data = found;
      m_pas  = 0;
      if (vc == 10'd480 && hc == 10'd0) begin
        slot = -1;
        for (int s = 2; s >= 0; s--) if (!m_live[s]) slot = s;
        for (int l = 0; l < 3; l++) begin
          blocked[l] = 0;
          for (int s = 0; s < 3; s++)
            if (m_live[s] && m_x[s] == lane_xs[l] && m_y[s] < 60) blocked[l] = 1;
        end
        base = lfsr_seq[m_idx];
        lane = -1;
        for (int k = 0; k < 3; k++)
          if (lane < 0 && !blocked[(base + k) % 3]) lane = (base + k) % 3;
        if (en_in) m_cnt = (m_cnt + 1 > SF) ? SF : m_cnt + 1;
        for (int s = 0; s < 3; s++) begin
          if (m_live[s]) begin
            if (m_kill[s] || col[s]) m_live[s] = 0;
            else if (en_in) begin
              if (m_y[s] + 2 + int'(vel) >= 480) begin m_live[s] = 0; m_pas = 1; end
              else m_y[s] = m_y[s] + 2 + int'(vel);
            end
          end
          m_kill[s] = 0;
        end
        if (en_in && m_cnt == SF && slot >= 0 && lane >= 0) begin
          m_live[slot] = 1; m_used[slot] = 1;
          m_x[slot] = lane_xs[lane]; m_y[slot] = 0; m_cnt = 0;
        end
      end else begin
        for (int s = 0; s < 3; s++) if (col[s]) m_kill[s] = 1;
      end
      m_idx = (m_idx + 1) % 7;
    end
    for (int s = 0; s < 3; s++) begin
      e.en[s]         = m_live[s];
      e.cmp[s]        = m_live[s] || !m_used[s];
      e.x[s*10 +: 10] = 10'(m_x[s]);
      e.y[s*10 +: 10] = 10'(m_y[s]);
    end
    e.data = m_data;
    e.rgb  = m_rgb;
    e.pas  = m_pas;
    q.push_back(e);
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("en", int'(en_o), int'(e.en));
      check("pasado", int'(pas_o), int'(e.pas));
      check("data", int'(data_o), int'(e.data));
      check("rgb", int'({red_o, green_o, blue_o}), int'(e.rgb));
      for (int s = 0; s < 3; s++) begin
        if (e.cmp[s]) begin
          check($sformatf("posx%0d", s), int'(posx_o[s*10 +: 10]), int'(e.x[s*10 +: 10]));
          check($sformatf("posy%0d", s), int'(posy_o[s*10 +: 10]), int'(e.y[s*10 +: 10]));
        end
      end
    end
  end

  task automatic cyc(input bit is_tick);
    @(negedge clock);
    if (is_tick) begin
      vc = 10'd480; hc = 10'd0;
    end else begin
      vc = 10'($urandom_range(0, 524)); hc = 10'($urandom_range(1, 799));
    end
    din  = 3'($urandom);
    rgbi = 24'($urandom);
    col  = (col_rate != 0 && $urandom_range(0, col_rate - 1) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    if (is_tick && want_hr)
      for (int s = 0; s < 3; s++)
        if (m_live[s] && m_y[s] + 2 + int'(vel) >= 480) begin col[s] = 1'b1; want_hr = 0; end
  endtask

  task automatic frame();
    repeat (3) cyc(0);
    cyc(1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) cyc(0);
    rst_n = 1'b1;
    repeat (250) frame();
    want_hr = 1;
    repeat (60) frame();
    want_hr = 0;
    col_rate = 30;
    repeat (40) frame();
    en_in = 1'b0;
    repeat (5) frame();
    en_in = 1'b1;
    col_rate = 0;
    repeat (20) frame();
    cyc(0); cyc(0);
    rst_n = 1'b0;
    cyc(0);
    rst_n = 1'b1;
    col_rate = 200;
    repeat (350) begin
      vel   = 2'($urandom_range(0, 3));
      en_in = ($urandom_range(0, 9) != 0);
      frame();
    end
    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
